// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes SPI slave command words into byte-RAM accesses and returns read data on a held tx handshake
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       err_cmd
);
    localparam int HW = TX_HOLD > 1 ? $clog2(TX_HOLD) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_TX} state_t;
    state_t state, state_nx;
    logic [1:0] op;
    logic [7:0] pay;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic wr_addr_vld, rd_addr_vld;
    logic [HW-1:0] hold_cnt;
    logic [7:0] rd_q;
    logic [7:0] mem [2**ADDR_SIZE];
    logic wr_go, rd_go, rej;
    assign op  = rx_data[9:8];
    assign pay = rx_data[7:0];
    always_comb begin
        wr_go    = rst_n && rx_valid && op == 2'b01 && wr_addr_vld;
        rd_go    = rst_n && rx_valid && op == 2'b11 && rd_addr_vld && state == ST_IDLE;
        rej      = rx_valid && ((op == 2'b01 && !wr_addr_vld) || (op == 2'b11 && !rd_go));
        state_nx = state;
        state_nx = state == ST_IDLE ? (rd_go ? ST_READ : ST_IDLE) :
                   state == ST_READ ? ST_TX :
                   hold_cnt == '0   ? ST_IDLE : ST_TX;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            err_cmd     <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            err_cmd <= rej;
            if (rx_valid && op == 2'b00) begin
                wr_addr     <= pay[ADDR_SIZE-1:0];
                wr_addr_vld <= 1'b1;
            end else if (wr_go) begin
                wr_addr <= wr_addr + ADDR_SIZE'(1);
            end
            if (rx_valid && op == 2'b10) begin
                rd_addr     <= pay[ADDR_SIZE-1:0];
                rd_addr_vld <= 1'b1;
            end else if (rd_go) begin
                rd_addr <= rd_addr + ADDR_SIZE'(1);
            end
            if (rd_go) busy <= 1'b1;
            if (state == ST_READ) begin
                tx_data  <= rd_q;
                tx_valid <= 1'b1;
                hold_cnt <= HW'(TX_HOLD - 1);
            end else if (state == ST_TX) begin
                if (hold_cnt == '0) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - HW'(1);
                end
            end
        end
    end
    // RAM is deliberately not reset; the read port snapshots the byte so later writes cannot disturb a pending response
    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_addr] <= pay;
        if (rd_go) rd_q <= mem[rd_addr];
    end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: scoreboard bench for spi_ram_ctrl; a small RAM model predicts read responses
module tb_spi_ram_ctrl;
    localparam int TX_HOLD = 9;
    logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic [7:0] tx_data;
    logic tx_valid, busy, err_cmd;
    typedef struct {
        logic [7:0] d;
        bit         k;
        int         c;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0, err_seen = 0, err_exp = 0, hold_n = 0;
    logic [7:0] mem_m [256];
    bit known [256];
    logic [7:0] wa = '0, ra = '0, held = '0;
    bit mon_en = 1'b0, abort = 1'b0, tv_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_ram_ctrl #(.ADDR_SIZE(8), .TX_HOLD(TX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .err_cmd(err_cmd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        if (err_cmd) err_seen++;
        if (tx_valid && !tv_q) begin
            held = tx_data;
            if (sb.size() == 0) chk("tx_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                if (e.k) begin
                    chk("tx_data", tx_data, e.d);
                    held = e.d;
                end
                chk("tx_start", cyc, e.c);
            end
            hold_n = 1;
        end else if (tx_valid) begin
            hold_n++;
            chk("tx_stable", tx_data, held);
        end else if (tv_q) begin
            if (abort) abort = 1'b0;
            else chk("tx_len", hold_n, TX_HOLD);
        end
        tv_q = tx_valid;
    end

    task automatic send(input logic [1:0] op, input logic [7:0] pay, input bit exp_err);
        bit acc;
        exp_t n;
        acc = op == 2'b11 && !exp_err;
        @(negedge clk);
        rx_data  = {op, pay};
        rx_valid = 1'b1;
        if (exp_err) err_exp++;
        if (op == 2'b00) wa = pay;
        else if (op == 2'b01 && !exp_err) begin
            mem_m[wa] = pay;
            known[wa] = 1'b1;
            wa++;
        end else if (op == 2'b10) ra = pay;
        else if (acc) begin
            n.d = mem_m[ra];
            n.k = known[ra];
            n.c = cyc + 2;
            sb.push_back(n);
            ra++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        chk("err_cmd", err_cmd, exp_err);
        if (acc) begin
            chk("busy", busy, 1);
            chk("tx_early", tx_valid, 0);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !tx_valid) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wa = '0;
        ra = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cmd, 0);
        chk("rst_tx_data", tx_data, 0);
        // read of an unwritten byte: timing only
        send(2'b10, 8'h05, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();
        // sequential writes/reads with auto-increment
        send(2'b00, 8'h00, 0);
        send(2'b01, 8'h3C, 0);
        send(2'b00, 8'h12, 0);
        send(2'b01, 8'hC3, 0);
        send(2'b00, 8'h10, 0);
        send(2'b01, 8'hA5, 0);
        send(2'b01, 8'h5A, 0);
        send(2'b10, 8'h10, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();
        send(2'b11, 8'h00, 0);
        wait_idle();
        send(2'b11, 8'h00, 0);
        wait_idle();
        // commands before addresses are rejected
        do_reset();
        send(2'b01, 8'h99, 1);
        send(2'b11, 8'h00, 1);
        send(2'b10, 8'h00, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();
        // address wrap-around
        send(2'b00, 8'hFF, 0);
        send(2'b01, 8'h11, 0);
        send(2'b01, 8'h22, 0);
        send(2'b10, 8'hFF, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();
        send(2'b11, 8'h00, 0);
        wait_idle();
        // overrun and write to the byte being returned
        send(2'b00, 8'h40, 0);
        send(2'b01, 8'hAB, 0);
        send(2'b10, 8'h40, 0);
        send(2'b11, 8'h00, 0);
        repeat (2) @(negedge clk);
        send(2'b11, 8'h00, 1);
        send(2'b00, 8'h40, 0);
        send(2'b01, 8'h77, 0);
        wait_idle();
        send(2'b10, 8'h40, 0);
        send(2'b11, 8'h00, 0);
        wait_idle();
        // reset during an active response
        send(2'b10, 8'h40, 0);
        send(2'b11, 8'h00, 0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wa = '0;
        ra = '0;
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        send(2'b11, 8'h00, 1);
        repeat (12) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("err_count", err_seen, err_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
